// File: rtl/align_sequencer_multi.sv
// Time-shares one alignment engine across NUM_CHAN ADC channels in ascending order, with a per-channel timeout.
// All outputs are registered. Define ALIGN_RETRY_EN to re-launch a timed-out channel up to MAX_RETRY times.
module align_sequencer_multi #(
  parameter int NUM_CHAN       = 10,
  parameter int CHAN_W         = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRY      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                training_start,
  input  logic [NUM_CHAN-1:0] chan_enable,
  input  logic                data_aligned,
  output logic [CHAN_W-1:0]   chan_sel,
  output logic                start_align,
  output logic                busy,
  output logic                done,
  output logic                all_channels_aligned,
  output logic [NUM_CHAN-1:0] aligned_mask,
  output logic [NUM_CHAN-1:0] failed_mask
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_NEXT, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [CHAN_W-1:0]   chan_sel_nxt;
  logic [NUM_CHAN-1:0] pend, pend_nxt, en_lat, en_nxt;
  logic [NUM_CHAN-1:0] am_nxt, fm_nxt, sel_oh, pend_left;
  logic                all_nxt, done_nxt, start_nxt, busy_nxt;
  logic [TW-1:0]       tcnt, tcnt_nxt;

`ifdef ALIGN_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_cnt, retry_nxt;
`endif

  function automatic logic [CHAN_W-1:0] lowest_idx(input logic [NUM_CHAN-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = CHAN_W'(i);
    end
  endfunction

  assign sel_oh    = NUM_CHAN'(1) << chan_sel;
  assign pend_left = pend & ~sel_oh;

  always_comb begin
    state_nxt    = state;
    chan_sel_nxt = chan_sel;
    pend_nxt     = pend;
    en_nxt       = en_lat;
    am_nxt       = aligned_mask;
    fm_nxt       = failed_mask;
    all_nxt      = all_channels_aligned;
    tcnt_nxt     = tcnt;
    done_nxt     = 1'b0;
`ifdef ALIGN_RETRY_EN
    retry_nxt    = retry_cnt;
`endif
    case (state)
      S_IDLE, S_DONE: begin
        if (training_start) begin
          pend_nxt = chan_enable;
          en_nxt   = chan_enable;
          am_nxt   = '0;
          fm_nxt   = '0;
          all_nxt  = 1'b0;
          if (chan_enable != '0) begin
            chan_sel_nxt = lowest_idx(chan_enable);
            state_nxt    = S_START;
          end else begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end
        end
      end
      S_START: begin
        tcnt_nxt  = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        tcnt_nxt = tcnt + TW'(1);
        // A response landing on the timeout cycle still counts as aligned.
        if (data_aligned) begin
          am_nxt    = aligned_mask | sel_oh;
          state_nxt = S_NEXT;
        end else if (tcnt == T_LAST) begin
`ifdef ALIGN_RETRY_EN
          if (retry_cnt < RW'(MAX_RETRY)) begin
            retry_nxt = retry_cnt + RW'(1);
            state_nxt = S_START;
          end else begin
            fm_nxt    = failed_mask | sel_oh;
            state_nxt = S_NEXT;
          end
`else
          fm_nxt    = failed_mask | sel_oh;
          state_nxt = S_NEXT;
`endif
        end
      end
      S_NEXT: begin
        pend_nxt = pend_left;
`ifdef ALIGN_RETRY_EN
        retry_nxt = '0;
`endif
        if (pend_left != '0) begin
          chan_sel_nxt = lowest_idx(pend_left);
          state_nxt    = S_START;
        end else begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          all_nxt   = (aligned_mask == en_lat) && (en_lat != '0);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    start_nxt = (state_nxt == S_START);
    busy_nxt  = (state_nxt == S_START) || (state_nxt == S_WAIT) || (state_nxt == S_NEXT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= S_IDLE;
      chan_sel             <= '0;
      start_align          <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      all_channels_aligned <= 1'b0;
      aligned_mask         <= '0;
      failed_mask          <= '0;
      pend                 <= '0;
      en_lat               <= '0;
      tcnt                 <= '0;
`ifdef ALIGN_RETRY_EN
      retry_cnt            <= '0;
`endif
    end else begin
      state                <= state_nxt;
      chan_sel             <= chan_sel_nxt;
      start_align          <= start_nxt;
      busy                 <= busy_nxt;
      done                 <= done_nxt;
      all_channels_aligned <= all_nxt;
      aligned_mask         <= am_nxt;
      failed_mask          <= fm_nxt;
      pend                 <= pend_nxt;
      en_lat               <= en_nxt;
      tcnt                 <= tcnt_nxt;
`ifdef ALIGN_RETRY_EN
      retry_cnt            <= retry_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_align_sequencer_multi.sv
// Bench for align_sequencer_multi: a responder model answers start_align pulses, a scoreboard
// checks the order of launched channels and the result reported on each done pulse.
module tb_align_sequencer_multi;

  localparam int NC = 10;
  localparam int CW = 4;
  localparam int TO = 256;
  localparam int MR = 2;
`ifdef ALIGN_RETRY_EN
  localparam int ATT = MR + 1;
`else
  localparam int ATT = 1;
`endif

  typedef struct packed {
    logic          all;
    logic [NC-1:0] am;
    logic [NC-1:0] fm;
  } done_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          training_start = 1'b0;
  logic [NC-1:0] chan_enable = '0;
  logic          data_aligned = 1'b0;
  logic [CW-1:0] chan_sel;
  logic          start_align, busy, done, all_channels_aligned;
  logic [NC-1:0] aligned_mask, failed_mask;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [CW-1:0] exp_sel_q[$];
  done_t         exp_done_q[$];
  logic [CW-1:0] mon_e;
  done_t         mon_d;
  done_t         obs_d;
  int resp_delay[NC];
  int resp_attempt[NC];
  int att_cnt[NC];
  int r_ch;

  align_sequencer_multi #(
    .NUM_CHAN(NC), .CHAN_W(CW), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst(rst), .training_start(training_start), .chan_enable(chan_enable),
    .data_aligned(data_aligned), .chan_sel(chan_sel), .start_align(start_align),
    .busy(busy), .done(done), .all_channels_aligned(all_channels_aligned),
    .aligned_mask(aligned_mask), .failed_mask(failed_mask)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Scoreboard: every start_align and done pulse consumes one expected entry.
  initial forever begin
    @(negedge clk);
    if (start_align === 1'b1) begin
      checks++;
      if (exp_sel_q.size() == 0) begin
        failures++;
        $display("FAIL sb_start: unexpected start_align on chan_sel=%0d, required none", chan_sel);
      end else begin
        mon_e = exp_sel_q.pop_front();
        if (chan_sel !== mon_e) begin
          failures++;
          $display("FAIL sb_start: chan_sel=%0d, required %0d", chan_sel, mon_e);
        end
      end
    end
    if (done === 1'b1) begin
      checks++;
      obs_d = {all_channels_aligned, aligned_mask, failed_mask};
      if (exp_done_q.size() == 0) begin
        failures++;
        $display("FAIL sb_done: unexpected done pulse, required none");
      end else begin
        mon_d = exp_done_q.pop_front();
        if (obs_d !== mon_d) begin
          failures++;
          $display("FAIL sb_done: all=%0b aligned=%h failed=%h, required all=%0b aligned=%h failed=%h",
                   obs_d.all, obs_d.am, obs_d.fm, mon_d.all, mon_d.am, mon_d.fm);
        end
      end
    end
  end

  // Engine model: answers attempt number resp_attempt[ch] after resp_delay[ch] cycles.
  initial forever begin
    @(negedge clk);
    if (start_align === 1'b1 && chan_sel < NC) begin
      r_ch = int'(chan_sel);
      att_cnt[r_ch]++;
      if (resp_attempt[r_ch] != 0 && att_cnt[r_ch] == resp_attempt[r_ch]) begin
        repeat (resp_delay[r_ch]) @(negedge clk);
        data_aligned = 1'b1;
        @(negedge clk);
        data_aligned = 1'b0;
      end
    end
  end

  task automatic set_resp(input int delay, input int attempt);
    for (int i = 0; i < NC; i++) begin
      resp_delay[i]   = delay;
      resp_attempt[i] = attempt;
      att_cnt[i]      = 0;
    end
  endtask

  task automatic push_seq(input logic [NC-1:0] en);
    for (int i = 0; i < NC; i++) if (en[i]) exp_sel_q.push_back(CW'(i));
  endtask

  // Called at a negedge; returns at the negedge of the cycle after the accepting edge.
  task automatic kick(input logic [NC-1:0] en);
    chan_enable    = en;
    training_start = 1'b1;
    @(negedge clk);
    training_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({chan_sel, start_align, busy, done, all_channels_aligned} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: sel=%0d start=%0b busy=%0b done=%0b all=%0b, required all 0",
               chan_sel, start_align, busy, done, all_channels_aligned);
    end
    checks++;
    if (aligned_mask !== '0 || failed_mask !== '0) begin
      failures++;
      $display("FAIL reset_masks: aligned=%h failed=%h, required 0/0", aligned_mask, failed_mask);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || start_align !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%0b start=%0b done=%0b, required 0", busy, start_align, done);
    end
  endtask

  task automatic test_all_channels;
    bit ok;
    set_resp(200, 1);
    push_seq(10'h3FF);
    exp_done_q.push_back(done_t'{all: 1'b1, am: 10'h3FF, fm: 10'h000});
    kick(10'h3FF);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL all_busy: busy=%0b in START, required 1", busy);
    end
    wait_done(NC * (210) + 50, ok);
    checks++;
    if (!ok || busy !== 1'b0) begin
      failures++;
      $display("FAIL all_done: done seen=%0b busy=%0b, required done with busy 0", ok, busy);
    end
    @(negedge clk);
    checks++;
    if (exp_sel_q.size() != 0 || exp_done_q.size() != 0) begin
      failures++;
      $display("FAIL all_sb: %0d starts and %0d dones outstanding, required 0", exp_sel_q.size(), exp_done_q.size());
    end
    checks++;
    if (done !== 1'b0 || all_channels_aligned !== 1'b1 || aligned_mask !== 10'h3FF) begin
      failures++;
      $display("FAIL all_hold: done=%0b all=%0b aligned=%h, required 0/1/3ff", done, all_channels_aligned, aligned_mask);
    end
  endtask

  task automatic test_sparse;
    bit ok;
    set_resp(20, 1);
    push_seq(10'b1000100101);
    exp_done_q.push_back(done_t'{all: 1'b1, am: 10'h225, fm: 10'h000});
    kick(10'b1000100101);
    wait_done(4 * 40 + 50, ok);
    @(negedge clk);
    checks++;
    if (!ok || exp_sel_q.size() != 0 || exp_done_q.size() != 0) begin
      failures++;
      $display("FAIL sparse: done seen=%0b starts left=%0d, required done and 0", ok, exp_sel_q.size());
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int n3, t3f, t3l, t4;
    set_resp(5, 1);
    resp_attempt[3] = 0;
    push_seq(10'h007);
    repeat (ATT) exp_sel_q.push_back(CW'(3));
    push_seq(10'h3F0);
    exp_done_q.push_back(done_t'{all: 1'b0, am: 10'h3F7, fm: 10'h008});
    n3 = 0; t3f = -1; t3l = -1; t4 = -1; ok = 1'b0;
    kick(10'h3FF);
    for (int i = 0; i < ATT * (TO + 2) + 200; i++) begin
      if (start_align === 1'b1) begin
        if (chan_sel === CW'(3)) begin
          n3++;
          if (t3f < 0) t3f = cyc;
          t3l = cyc;
        end
        if (chan_sel === CW'(4) && t4 < 0) t4 = cyc;
      end
      if (done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok || n3 != ATT) begin
      failures++;
      $display("FAIL timeout_starts: done seen=%0b ch3 starts=%0d, required done and %0d", ok, n3, ATT);
    end
    checks++;
    if (t4 - t3l != TO + 2) begin
      failures++;
      $display("FAIL timeout_gap: ch3->ch4 start gap=%0d, required %0d", t4 - t3l, TO + 2);
    end
`ifdef ALIGN_RETRY_EN
    checks++;
    if (t3l - t3f != MR * (TO + 1)) begin
      failures++;
      $display("FAIL retry_gap: first->last ch3 start=%0d, required %0d", t3l - t3f, MR * (TO + 1));
    end
`endif
    @(negedge clk);
    checks++;
    if (exp_sel_q.size() != 0 || exp_done_q.size() != 0) begin
      failures++;
      $display("FAIL timeout_sb: %0d starts outstanding, required 0", exp_sel_q.size());
    end
  endtask

  task automatic test_retry_second;
    bit ok;
    set_resp(5, 1);
    resp_attempt[3] = 2;
    push_seq(10'h00F);
`ifdef ALIGN_RETRY_EN
    exp_sel_q.push_back(CW'(3));
    exp_done_q.push_back(done_t'{all: 1'b1, am: 10'h3FF, fm: 10'h000});
`else
    exp_done_q.push_back(done_t'{all: 1'b0, am: 10'h3F7, fm: 10'h008});
`endif
    push_seq(10'h3F0);
    kick(10'h3FF);
    wait_done(ATT * (TO + 2) + 200, ok);
    @(negedge clk);
    checks++;
    if (!ok || exp_sel_q.size() != 0 || exp_done_q.size() != 0) begin
      failures++;
      $display("FAIL retry_second: done seen=%0b starts left=%0d, required done and 0", ok, exp_sel_q.size());
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    set_resp(3, 1);
    resp_attempt[6] = 0;
    push_seq(10'h07F);
    kick(10'h3FF);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (start_align === 1'b1 && chan_sel === CW'(6)) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chan_enable    = '0;
    training_start = 1'b1;
    @(negedge clk);
    training_start = 1'b0;
    @(negedge clk);
    checks++;
    if (!ok || busy !== 1'b1 || chan_sel !== CW'(6) || done !== 1'b0 || aligned_mask !== 10'h03F) begin
      failures++;
      $display("FAIL mid_ignore: reached=%0b busy=%0b sel=%0d done=%0b aligned=%h, required 1/1/6/0/03f",
               ok, busy, chan_sel, done, aligned_mask);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({chan_sel, start_align, busy, done, all_channels_aligned, aligned_mask, failed_mask} !== '0) begin
      failures++;
      $display("FAIL reset_async: sel=%0d busy=%0b aligned=%h failed=%h, required all 0",
               chan_sel, busy, aligned_mask, failed_mask);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (exp_sel_q.size() != 0 || exp_done_q.size() != 0) begin
      failures++;
      $display("FAIL mid_sb: %0d starts outstanding, required 0", exp_sel_q.size());
    end
    set_resp(3, 1);
    push_seq(10'h3FF);
    exp_done_q.push_back(done_t'{all: 1'b1, am: 10'h3FF, fm: 10'h000});
    kick(10'h3FF);
    checks++;
    if (chan_sel !== '0 || start_align !== 1'b1) begin
      failures++;
      $display("FAIL restart: sel=%0d start=%0b, required 0/1", chan_sel, start_align);
    end
    wait_done(NC * 10 + 50, ok);
    @(negedge clk);
    checks++;
    if (!ok || exp_sel_q.size() != 0 || exp_done_q.size() != 0) begin
      failures++;
      $display("FAIL restart_sweep: done seen=%0b starts left=%0d, required done and 0", ok, exp_sel_q.size());
    end
  endtask

  task automatic test_empty_and_coincide;
    bit ok;
    bit seen;
    set_resp(3, 1);
    exp_done_q.push_back(done_t'{all: 1'b0, am: 10'h000, fm: 10'h000});
    kick(10'h000);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL empty_done: done=%0b busy=%0b on the cycle after start, required 1/0", done, busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL empty_quiet: busy or done asserted after empty sweep, required 0");
    end
    set_resp(TO, 1);
    push_seq(10'h002);
    exp_done_q.push_back(done_t'{all: 1'b1, am: 10'h002, fm: 10'h000});
    kick(10'h002);
    wait_done(TO + 50, ok);
    @(negedge clk);
    checks++;
    if (!ok || exp_sel_q.size() != 0 || exp_done_q.size() != 0 || failed_mask !== '0) begin
      failures++;
      $display("FAIL coincide: done seen=%0b failed=%h, required done and 000", ok, failed_mask);
    end
    set_resp(TO + 1, 1);
    repeat (ATT) exp_sel_q.push_back(CW'(1));
    exp_done_q.push_back(done_t'{all: 1'b0, am: 10'h000, fm: 10'h002});
    kick(10'h002);
    wait_done(ATT * (TO + 2) + 50, ok);
    @(negedge clk);
    checks++;
    if (!ok || exp_sel_q.size() != 0 || exp_done_q.size() != 0) begin
      failures++;
      $display("FAIL late_ignored: done seen=%0b starts left=%0d, required done and 0", ok, exp_sel_q.size());
    end
  endtask

  initial begin
    set_resp(3, 1);
    test_reset;
    test_all_channels;
    test_sparse;
    test_timeout;
    test_retry_second;
    test_reset_mid;
    test_empty_and_coincide;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
